// File: rtl/sym_vn_lut_loader.sv
// sym_vn_lut_loader
//   Write-side controller that fills the symmetric VN IB lookup RAM from a
//   valid/ready entry stream and tells the decoder when the RAM write port
//   is owned (read ports 1 and 3 are unusable while we is high).
//
// Ports
//   write_clk   single clock, shared with the RAM write port
//   rstn        asynchronous active-low reset
//   load_req    start pulse, sampled only in IDLE
//   load_base   first write address (latched with load_req)
//   load_len    entry count, 0 means DEPTH (latched with load_req)
//   load_abort  abandon the load in progress
//   in_data     stream entry
//   in_valid    stream entry valid
//   in_ready    loader accepts an entry this cycle (combinational)
//   lut_in      RAM write data
//   write_addr  RAM write address
//   we          RAM write enable
//   lut_busy    decoder must not issue VN LUT reads
//   load_done   one-cycle pulse when all entries are written
//   req_err     sticky: load_req seen while not IDLE
module sym_vn_lut_loader #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                  write_clk,
  input  logic                  rstn,
  input  logic                  load_req,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic                  load_abort,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] lut_in,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  we,
  output logic                  lut_busy,
  output logic                  load_done,
  output logic                  req_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  // One bit wider than the address so a full-depth load (len==0) fits.
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] lut_in_q, lut_in_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic                  we_q, we_d;
  logic                  lut_busy_q, lut_busy_d;
  logic                  load_done_q, load_done_d;
  logic                  req_err_q, req_err_d;
  logic                  accept;

  // Abort forces ready low so an abort cycle never consumes an entry.
  assign in_ready = (state_q == S_LOAD) && (remaining_q != '0) && !load_abort;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    lut_in_d     = lut_in_q;
    write_addr_d = write_addr_q;
    we_d         = 1'b0;
    lut_busy_d   = lut_busy_q;
    load_done_d  = 1'b0;
    req_err_d    = req_err_q;

    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          addr_d      = load_base;
          remaining_d = (load_len == '0) ? (ADDR_WIDTH + 1)'(DEPTH)
                                         : {1'b0, load_len};
          lut_busy_d  = 1'b1;
          req_err_d   = 1'b0;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (load_req) req_err_d = 1'b1;
        if (load_abort) begin
          lut_busy_d = 1'b0;
          state_d    = S_IDLE;
        end else if (accept) begin
          lut_in_d     = in_data;
          write_addr_d = addr_q;
          we_d         = 1'b1;
          addr_d       = addr_q + ADDR_WIDTH'(1);
          remaining_d  = remaining_q - (ADDR_WIDTH + 1)'(1);
          if (remaining_q == (ADDR_WIDTH + 1)'(1)) state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (load_req) req_err_d = 1'b1;
        lut_busy_d = 1'b0;
        state_d    = S_IDLE;
        // The RAM commits the final entry on this edge; done only if not aborted.
        if (!load_abort) load_done_d = 1'b1;
      end

      default: begin
        lut_busy_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      lut_in_q     <= '0;
      write_addr_q <= '0;
      we_q         <= 1'b0;
      lut_busy_q   <= 1'b0;
      load_done_q  <= 1'b0;
      req_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      lut_in_q     <= lut_in_d;
      write_addr_q <= write_addr_d;
      we_q         <= we_d;
      lut_busy_q   <= lut_busy_d;
      load_done_q  <= load_done_d;
      req_err_q    <= req_err_d;
    end
  end

  assign lut_in     = lut_in_q;
  assign write_addr = write_addr_q;
  assign we         = we_q;
  assign lut_busy   = lut_busy_q;
  assign load_done  = load_done_q;
  assign req_err    = req_err_q;

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
module tb_sym_vn_lut_loader;

  logic       write_clk = 1'b0;
  logic       rstn;
  logic       load_req;
  logic [6:0] load_base;
  logic [6:0] load_len;
  logic       load_abort;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] lut_in;
  logic [6:0] write_addr;
  logic       we;
  logic       lut_busy;
  logic       load_done;
  logic       req_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the LUT RAM write port plus a write log.
  logic [3:0] ram [128];
  int         log_addr [$];
  int         log_data [$];

  always #5 write_clk = ~write_clk;

  always @(posedge write_clk) begin
    if (we === 1'b1) begin
      ram[write_addr] <= lut_in;
      log_addr.push_back(int'(write_addr));
      log_data.push_back(int'(lut_in));
    end
  end

  sym_vn_lut_loader #(
    .DATA_WIDTH(4),
    .ADDR_WIDTH(7),
    .DEPTH(128)
  ) dut (
    .write_clk (write_clk),
    .rstn      (rstn),
    .load_req  (load_req),
    .load_base (load_base),
    .load_len  (load_len),
    .load_abort(load_abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lut_in    (lut_in),
    .write_addr(write_addr),
    .we        (we),
    .lut_busy  (lut_busy),
    .load_done (load_done),
    .req_err   (req_err)
  );

  // Entry: just after a posedge. Exit: 1 time unit after the next posedge.
  task automatic step(input logic v, input logic [3:0] d, output logic acc);
    in_valid = v;
    in_data  = d;
    #1;
    acc = in_valid && in_ready;
    @(posedge write_clk);
    #1;
  endtask

  task automatic start_load(input logic [6:0] base, input logic [6:0] len);
    load_base = base;
    load_len  = len;
    load_req  = 1'b1;
    @(posedge write_clk);
    #1;
    load_req = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({lut_in, write_addr, we, lut_busy, load_done, req_err, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {lut_in, write_addr, we, lut_busy, load_done, req_err, in_ready});
    end
    @(negedge write_clk);
    rstn = 1'b1;
    @(posedge write_clk);
    #1;
    checks++;
    if ({we, lut_busy, load_done, req_err, in_ready} !== 5'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b required 00000",
               {we, lut_busy, load_done, req_err, in_ready});
    end
  endtask

  task automatic test_full_load;
    int cyc, idx, bad;
    logic acc, done;
    log_addr.delete(); log_data.delete();
    start_load(7'd0, 7'd0);
    cyc = 1; idx = 0; done = 1'b0;
    checks++;
    if (lut_busy !== 1'b1) begin
      errors++; $display("FAIL full_busy_rise: got %b required 1", lut_busy);
    end
    while (!done && cyc < 300) begin
      step(1'b1, idx[3:0], acc);
      cyc++;
      if (acc) idx++;
      if (load_done === 1'b1) begin
        done = 1'b1;
        checks++;
        if (cyc != 130) begin
          errors++; $display("FAIL full_latency: got %0d required 130", cyc);
        end
        checks++;
        if ({lut_busy, we} !== 2'b00) begin
          errors++; $display("FAIL full_done_edge: got busy,we=%b required 00", {lut_busy, we});
        end
      end else if (lut_busy !== 1'b1) begin
        checks++; errors++;
        $display("FAIL full_busy_hold: got %b required 1 at cycle %0d", lut_busy, cyc);
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL full_timeout: got no load_done required load_done");
    end
    checks++;
    if (log_addr.size() != 128 || idx != 128) begin
      errors++;
      $display("FAIL full_write_count: got %0d writes %0d accepts required 128",
               log_addr.size(), idx);
    end
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (i < log_addr.size() && log_addr[i] != i) bad++;
      if (ram[i] !== 4'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL full_contents: got %0d bad entries required 0", bad);
    end
    step(1'b0, 4'h0, acc);
    checks++;
    if (load_done !== 1'b0) begin
      errors++; $display("FAIL full_done_pulse: got %b required 0", load_done);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] pat;
    int idx, i, bad;
    logic acc, done, v;
    pat = 8'b1101_1001;
    log_addr.delete(); log_data.delete();
    start_load(7'd10, 7'd5);
    idx = 0; i = 0; done = 1'b0; bad = 0;
    checks++;
    if (we !== 1'b0) begin
      errors++; $display("FAIL bp_we_idle: got %b required 0", we);
    end
    while (!done && i < 20) begin
      v = (i < 8) ? pat[i] : 1'b1;
      step(v, 4'(idx + 1), acc);
      if (we !== acc) bad++;
      if (acc) idx++;
      if (load_done === 1'b1) done = 1'b1;
      else if (idx == 5 && in_ready !== 1'b0) bad++;
      i++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_we_follows_accept: got %0d bad cycles required 0", bad);
    end
    checks++;
    if (!done || i != 9) begin
      errors++; $display("FAIL bp_done_cycle: got done=%b at step %0d required 1 at 9", done, i);
    end
    checks++;
    if (idx != 5) begin
      errors++; $display("FAIL bp_accept_count: got %0d required 5", idx);
    end
    bad = 0;
    for (int k = 0; k < 5; k++)
      if (k >= log_addr.size() || log_addr[k] != 10 + k || log_data[k] != k + 1) bad++;
    checks++;
    if (bad != 0 || log_addr.size() != 5) begin
      errors++;
      $display("FAIL bp_write_seq: got %0d writes %0d bad required 5 writes 0 bad",
               log_addr.size(), bad);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wrap;
    int idx, cyc;
    logic acc, done, prev_we;
    log_addr.delete(); log_data.delete();
    start_load(7'd126, 7'd3);
    idx = 0; cyc = 1; done = 1'b0; prev_we = 1'b0;
    while (!done && cyc < 20) begin
      prev_we = we;
      step(1'b1, 4'(4'hA + idx), acc);
      cyc++;
      if (acc) idx++;
      if (load_done === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done || cyc != 5 || prev_we !== 1'b1 || we !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done: got done=%b cyc=%0d prev_we=%b we=%b required 1 5 1 0",
               done, cyc, prev_we, we);
    end
    checks++;
    if (log_addr.size() != 3 || log_addr[0] != 126 || log_addr[1] != 127 || log_addr[2] != 0
        || log_data[0] != 10 || log_data[1] != 11 || log_data[2] != 12) begin
      errors++;
      $display("FAIL wrap_writes: got %0d writes required (126,A)(127,B)(0,C)", log_addr.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort;
    int idx, cyc, guard;
    logic acc, done, seen;
    log_addr.delete(); log_data.delete();
    start_load(7'd40, 7'd20);
    idx = 0; guard = 0;
    while (idx < 7 && guard < 50) begin
      step(1'b1, 4'(idx), acc);
      if (acc) idx++;
      guard++;
    end
    load_abort = 1'b1;
    in_valid   = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_ready_low: got %b required 0", in_ready);
    end
    step(1'b1, 4'hF, acc);
    load_abort = 1'b0;
    checks++;
    if ({acc, we, lut_busy, in_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_stop: got acc,we,busy,ready=%b required 0000",
               {acc, we, lut_busy, in_ready});
    end
    checks++;
    if (log_addr.size() != 7) begin
      errors++; $display("FAIL abort_write_count: got %0d required 7", log_addr.size());
    end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'h0, acc);
      if (load_done !== 1'b0 || we !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL abort_no_done: got done/we activity required none");
    end
    log_addr.delete(); log_data.delete();
    start_load(7'd5, 7'd2);
    idx = 0; cyc = 1; done = 1'b0;
    while (!done && cyc < 20) begin
      step(1'b1, 4'(3 + idx), acc);
      cyc++;
      if (acc) idx++;
      if (load_done === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done || cyc != 4 || log_addr.size() != 2 || log_addr[0] != 5 || log_addr[1] != 6
        || log_data[0] != 3 || log_data[1] != 4) begin
      errors++;
      $display("FAIL abort_reload: got done=%b cyc=%0d writes=%0d required 1 4 2",
               done, cyc, log_addr.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_illegal_req;
    int idx, cyc;
    logic acc, done, injected;
    log_addr.delete(); log_data.delete();
    start_load(7'd60, 7'd4);
    idx = 0; cyc = 1; done = 1'b0; injected = 1'b0;
    while (!done && cyc < 20) begin
      if (idx == 2 && !injected) begin
        load_req  = 1'b1;
        load_base = 7'd0;
        load_len  = 7'd1;
      end
      step(1'b1, 4'(idx + 1), acc);
      if (load_req) begin
        load_req = 1'b0;
        injected = 1'b1;
        checks++;
        if (req_err !== 1'b1) begin
          errors++; $display("FAIL illegal_req_err_set: got %b required 1", req_err);
        end
      end
      cyc++;
      if (acc) idx++;
      if (load_done === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done || cyc != 6 || log_addr.size() != 4 || log_addr[0] != 60 || log_addr[3] != 63
        || log_data[0] != 1 || log_data[3] != 4) begin
      errors++;
      $display("FAIL illegal_load_unchanged: got done=%b cyc=%0d writes=%0d required 1 6 4",
               done, cyc, log_addr.size());
    end
    checks++;
    if (req_err !== 1'b1) begin
      errors++; $display("FAIL illegal_req_err_sticky: got %b required 1", req_err);
    end
    in_valid = 1'b0;
    log_addr.delete(); log_data.delete();
    start_load(7'd100, 7'd1);
    checks++;
    if (req_err !== 1'b0) begin
      errors++; $display("FAIL illegal_req_err_clear: got %b required 0", req_err);
    end
    done = 1'b0; cyc = 1;
    while (!done && cyc < 20) begin
      step(1'b1, 4'h9, acc);
      cyc++;
      if (load_done === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done || log_addr.size() != 1 || log_addr[0] != 100 || log_data[0] != 9) begin
      errors++;
      $display("FAIL illegal_next_load: got done=%b writes=%0d required 1 1", done, log_addr.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    logic acc, seen;
    start_load(7'd0, 7'd10);
    for (int k = 0; k < 3; k++) step(1'b1, 4'(k), acc);
    checks++;
    if (we !== 1'b1) begin
      errors++; $display("FAIL areset_precondition: got we=%b required 1", we);
    end
    in_valid = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({we, lut_busy, in_ready, load_done} !== 4'b0000) begin
      errors++;
      $display("FAIL areset_immediate: got we,busy,ready,done=%b required 0000",
               {we, lut_busy, in_ready, load_done});
    end
    repeat (2) @(posedge write_clk);
    @(negedge write_clk);
    rstn = 1'b1;
    @(posedge write_clk);
    #1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 4'h0, acc);
      if (load_done !== 1'b0 || we !== 1'b0 || lut_busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL areset_no_done: got activity after reset required none");
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    load_req   = 1'b0;
    load_base  = '0;
    load_len   = '0;
    load_abort = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    #12;
    test_reset();
    test_full_load();
    test_backpressure();
    test_wrap();
    test_abort();
    test_illegal_req();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sym_vn_lut_loader.md
Name: sym_vn_lut_loader

Overview:
Write-side controller that fills the symmetric VN IB lookup RAM (4-bit entries, 128-deep, 7-bit address) from a valid/ready entry stream. It sits between the IB table source (ROM or host stream) and the VN LUT RAM's write port. It drives lut_in/write_addr/we and tells the decoder when the LUT write port is owned. While we is high, read ports 1 and 3 of the RAM are unusable, so the decoder must hold off VN reads while lut_busy is high.

Parameters:
DATA_WIDTH, 4, LUT entry width (matches RAM lut_in)
ADDR_WIDTH, 7, LUT address width
DEPTH, 128, LUT entries (2**ADDR_WIDTH)

Ports:
write_clk  in  1  single clock, same clock as the RAM write port
rstn  in  1  asynchronous active-low reset
load_req  in  1  1-cycle start pulse, sampled only in IDLE
load_base  in  ADDR_WIDTH  first write address, latched with load_req
load_len  in  ADDR_WIDTH  entries to write; 0 means DEPTH (128); latched with load_req
load_abort  in  1  abandon the load in progress
in_data  in  DATA_WIDTH  stream entry
in_valid  in  1  stream entry valid
in_ready  out  1  loader accepts an entry this cycle
lut_in  out  DATA_WIDTH  to RAM D
write_addr  out  ADDR_WIDTH  to RAM write address
we  out  1  to RAM WE
lut_busy  out  1  decoder must not issue VN LUT reads
load_done  out  1  1-cycle pulse: all entries written
req_err  out  1  sticky: load_req arrived while not IDLE

Behaviour:
- Async reset (rstn=0): state IDLE; lut_in=0, write_addr=0, we=0, lut_busy=0, load_done=0, req_err=0, internal counters=0. in_ready=0 during reset.
- All outputs are registered except in_ready. in_ready = (state==LOAD) && (remaining!=0) && !load_abort.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - On load_req=1: latch base/len (remaining = len, or DEPTH if len==0) and go to LOAD.
  - lut_busy goes to 1 on that same edge.
  - An accepted load_req clears req_err.
- LOAD:
  - An entry is accepted when in_valid && in_ready.
  - On the accept edge: lut_in<=in_data, write_addr<=current address, we<=1. The address then increments modulo DEPTH (127 wraps to 0) and remaining is decremented.
  - A cycle with no accept registers we<=0. Bubbles in in_valid are therefore allowed and only produce gaps.
  - Latency: the RAM write occurs one edge after the accept edge.
- LOAD -> FLUSH: on the edge that accepts the last entry. we=1 is registered for that entry.
- FLUSH, one cycle: on the next edge the RAM commits the last entry, and in the same edge we<=0, load_done<=1, lut_busy<=0, state<=IDLE.
- load_done is high for exactly one cycle. lut_busy falls on the same edge that load_done rises.
- load_abort:
  - In LOAD or FLUSH, on the next edge: state<=IDLE, we<=0, lut_busy<=0, no load_done.
  - Abort takes priority over an accept in the same cycle; in_ready is already 0 that cycle.
  - RAM contents after an abort are undefined.
  - In IDLE, load_abort has no effect.
- load_req in LOAD or FLUSH: ignored and req_err<=1. This also applies to load_req in the same cycle as load_abort.
- Minimum load time is len+2 cycles from load_req to load_done with continuous in_valid.
- Between loads, lut_in and write_addr hold their last values; we stays 0.
- Reset mid-load: all outputs return to reset values immediately and asynchronously. No load_done is produced.

Test Plan:
1. Full load, continuous stream:
   - Stimulus: rstn release; load_req with base=0, len=0; in_data = addr[3:0] with in_valid held 1.
   - Response: 128 cycles of we=1 with write_addr 0..127; load_done exactly 130 cycles after load_req; lut_busy high from req+1 through the load_done edge.
   - Readback of all 4 RAM ports matches addr[3:0].
2. Backpressure and bubbles:
   - Stimulus: len=5, base=10; in_valid toggles 1,0,0,1,1,0,1,1.
   - Response: we pulses only after accepts; write_addr sequence is 10,11,12,13,14; in_ready drops after the 5th accept; extra valid data is not consumed.
3. Wrap-around:
   - Stimulus: base=126, len=3, data 0xA,0xB,0xC.
   - Response: writes go to 126, 127, 0 with data A, B, C; load_done one cycle after the last we.
4. Abort:
   - Stimulus: len=20; assert load_abort after the 7th accept.
   - Response: next edge gives we=0, lut_busy=0, state IDLE; no load_done.
   - A new load_req is then accepted normally.
5. Illegal request:
   - Stimulus: load_req during LOAD.
   - Response: req_err=1 and the current load completes unchanged. The next legal load_req clears req_err.
6. Async reset mid-load:
   - Stimulus: drop rstn mid-cycle during LOAD with we=1.
   - Response: we, lut_busy and in_ready go to 0 without a clock edge; load_done is never asserted.
